mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single-port, word-wide system RAM between the CPU instruction-fetch port and the CPU load/store port. Sits between `riscv_cpu` and `ram` in `top`, replacing the direct CPU–RAM connection. Each port uses a request/acknowledge handshake. The arbiter sequences one RAM access at a time through a three-state FSM.

## Interface
Parameters:
- `ADDR_W`, 32, address width of all ports.
- `DATA_W`, 32, data width of all ports.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `if_req_i`  in  1  fetch request; held until `if_ack_o`.
- `if_addr_i`  in  ADDR_W  fetch address.
- `if_ack_o`  out  1  one-cycle pulse; `if_rdata_o` valid this cycle.
- `if_rdata_o`  out  DATA_W  fetched word.
- `d_req_i`  in  1  load/store request; held until `d_ack_o`.
- `d_we_i`  in  1  1 = store, 0 = load.
- `d_addr_i`  in  ADDR_W  load/store address.
- `d_wdata_i`  in  DATA_W  store data.
- `d_ack_o`  out  1  one-cycle pulse; completes the load or store.
- `d_rdata_o`  out  DATA_W  load data, valid with `d_ack_o`.
- `ram_we_o`  out  1  RAM write enable.
- `ram_addr_o`  out  ADDR_W  RAM address.
- `ram_data_o`  out  DATA_W  RAM write data.
- `ram_data_i`  in  DATA_W  RAM read data; registered, valid one cycle after the address.

## Operation
FSM states and transitions:
- **IDLE**
  - If any request is high, pick a winner and latch its address, write data and write flag into registers.
  - Record the owner and go to ACCESS.
  - With no request, stay in IDLE.
- **ACCESS**
  - `ram_addr_o`, `ram_data_o` and `ram_we_o` are driven from the latched registers.
  - `ram_we_o` is 1 only for a store, and only in this state.
  - Always go to RESP.
- **RESP**
  - Pulse the owner's ack.
  - Drive the owner's rdata from `ram_data_i`. For stores, rdata is don't-care.
  - Always go to IDLE.

Arbitration and handshake rules:
- Winner selection is set by the configuration macro below.
- A requester must drop `req` or present a new request in the cycle after its ack.
- Requests arriving during ACCESS or RESP wait for IDLE.
- Input changes during ACCESS or RESP are ignored, because the transaction was latched in IDLE.
- Outside ACCESS, `ram_we_o` = 0. `ram_addr_o` and `ram_data_o` hold their last latched value.
- Fetch is read-only and never writes.
- Addresses pass through unchanged. Word alignment is the CPU's responsibility.

## Timing
- Request seen high in IDLE at cycle N: ACCESS at N+1, ack and rdata at N+2, IDLE at N+3.
- Minimum request-to-ack latency is 2 cycles. Peak throughput is one access per 3 cycles.
- Reset values:
  - state = IDLE
  - `if_ack_o` = `d_ack_o` = 0
  - `ram_we_o` = 0
  - `ram_addr_o` = `ram_data_o` = 0
  - `if_rdata_o` = `d_rdata_o` = 0
  - last-owner = data (so fetch wins the first tie).
- Reset during ACCESS or RESP:
  - The transaction is abandoned and no ack is issued.
  - `ram_we_o` is 0 from the cycle after reset is sampled.
  - The requester re-requests after reset.
- Simultaneous requests in IDLE are resolved by the arbitration policy. The loser stays pending and is served on the next IDLE.
- The acks are mutually exclusive and never asserted in the same cycle.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - On a tie, the port that did not own the previous transaction wins.
  - The last-owner register updates on every grant.
  - A continuously requesting port cannot starve the other. Worst-case wait is one transaction, about 3 cycles.
- Not defined:
  - Fixed priority: data always beats fetch.
  - The last-owner register is not implemented.
  - Fetch may starve under continuous data traffic.

## Structure
- Package `pillar_mem_pkg` holds:
  - the FSM state enum (`ARB_IDLE`, `ARB_ACCESS`, `ARB_RESP`);
  - the owner enum (`OWN_IF`, `OWN_D`);
  - default `ADDR_W` and `DATA_W` constants.
- One sub-module, `arb_pick2`: combinational two-way winner select from the two requests and last-owner, with policy chosen by the macro.
- The FSM, latches and RAM drive stay in `mem_arbiter`.

## Test plan
- Reset, then fetch-only request for addr 0x0000_0010, with RAM word = 0x0000_0013 → `if_ack_o` pulses at N+2 with `if_rdata_o` = 0x0000_0013. `ram_we_o` stays 0 throughout.
- Data store to addr 0x40 with data 0xDEAD_BEEF → `ram_we_o` = 1 for exactly one cycle (ACCESS) with addr 0x40. Then a load from 0x40 returns 0xDEAD_BEEF on `d_ack_o`.
- Simultaneous fetch and data requests from reset:
  - Round-robin build: fetch is acked first, data 3 cycles later.
  - Fixed build: data first.
- Both ports requesting continuously for 12 cycles:
  - Round-robin build: acks alternate IF, D, IF, D.
  - Fixed build: only `d_ack_o` pulses.
- Reset asserted in ACCESS of a store → no ack, `ram_we_o` = 0 the next cycle, outputs at reset values. The store is reissued after reset and completes normally.
- `d_addr_i` changed during ACCESS → RAM still sees the address latched in IDLE, and the ack returns the original word.

Source files
------------

// File: rtl/pillar_mem_pkg.sv
// Shared types and defaults for the CPU memory arbiter.
// Holds the arbiter FSM state enum, the owner enum, and default bus widths.
package pillar_mem_pkg;

  localparam int ADDR_W_DEFAULT = 32;
  localparam int DATA_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/arb_pick2.sv
// Two-way winner select between the fetch port and the load/store port.
// MEM_ARB_ROUND_ROBIN_EN defined: a tie goes to the port that did not own
// the previous transaction. Undefined: fixed priority, data beats fetch.
module arb_pick2
  import pillar_mem_pkg::*;
(
  input  logic   if_req_i,
  input  logic   d_req_i,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  owner_e last_i,
`endif
  output logic   valid_o,
  output owner_e win_o
);

  // Pure combinational pick; the caller only uses win_o when valid_o is high.
  always_comb begin
    valid_o = if_req_i | d_req_i;
    win_o   = OWN_D;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (if_req_i && d_req_i) begin
      win_o = (last_i == OWN_D) ? OWN_IF : OWN_D;
    end else if (if_req_i) begin
      win_o = OWN_IF;
    end
`else
    if (if_req_i && !d_req_i) begin
      win_o = OWN_IF;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port system RAM between CPU fetch and load/store ports.
// One RAM access at a time: IDLE (arbitrate and latch) -> ACCESS (drive RAM)
// -> RESP (ack the owner, return RAM read data).
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (round-robin tie break);
// without it data always beats fetch.
//
// Handshake: a port raises req with its address/data and holds them until
// it sees its one-cycle ack; in the cycle after the ack it must drop req or
// present a new request. Everything a transaction needs is captured in IDLE,
// so input changes during ACCESS/RESP have no effect.
module mem_arbiter
  import pillar_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_ack_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i,
  output arb_state_e        state_o
);

  arb_state_e        state_q;
  owner_e            owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ram_we_q;
  logic              if_ack_q;
  logic              d_ack_q;
  logic              win_valid_d;
  owner_e            win_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_e            last_q;
`endif

  arb_pick2 u_pick (
    .if_req_i (if_req_i),
    .d_req_i  (d_req_i),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .last_i   (last_q),
`endif
    .valid_o  (win_valid_d),
    .win_o    (win_d)
  );

  // Arbiter FSM with registered RAM drive and acks; write enable is only
  // ever high during ACCESS, and acks only during RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWN_D;
      addr_q   <= '0;
      wdata_q  <= '0;
      ram_we_q <= 1'b0;
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_q   <= OWN_D;
`endif
    end else begin
      ram_we_q <= 1'b0;
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (win_valid_d) begin
            owner_q <= win_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q  <= win_d;
`endif
            if (win_d == OWN_D) begin
              addr_q   <= d_addr_i;
              wdata_q  <= d_wdata_i;
              ram_we_q <= d_we_i;
            end else begin
              // Fetch is read-only; write data keeps its last latched value.
              addr_q <= if_addr_i;
            end
            state_q <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          if_ack_q <= (owner_q == OWN_IF);
          d_ack_q  <= (owner_q == OWN_D);
          state_q  <= ARB_RESP;
        end
        ARB_RESP: begin
          state_q <= ARB_IDLE;
        end
        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  // RAM read data arrives registered in RESP; route it to the acked port only.
  always_comb begin
    if_rdata_o = if_ack_q ? ram_data_i : '0;
    d_rdata_o  = d_ack_q  ? ram_data_i : '0;
  end

  assign if_ack_o   = if_ack_q;
  assign d_ack_o    = d_ack_q;
  assign ram_we_o   = ram_we_q;
  assign ram_addr_o = addr_q;
  assign ram_data_o = wdata_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed transactions, a RAM model
// with one-cycle registered read, and a transaction-timeline reference model
// compared against the DUT outputs on every negative clock edge.
module tb_mem_arbiter;
  import pillar_mem_pkg::*;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_ack_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i = 1'b0;
  logic        d_we_i = 1'b0;
  logic [31:0] d_addr_i = '0;
  logic [31:0] d_wdata_i = '0;
  logic        d_ack_o;
  logic [31:0] d_rdata_o;
  logic        ram_we_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_data_o;
  logic [31:0] ram_data_i = '0;
  arb_state_e  state_o;

  mem_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_ack_o   (if_ack_o),
    .if_rdata_o (if_rdata_o),
    .d_req_i    (d_req_i),
    .d_we_i     (d_we_i),
    .d_addr_i   (d_addr_i),
    .d_wdata_i  (d_wdata_i),
    .d_ack_o    (d_ack_o),
    .d_rdata_o  (d_rdata_o),
    .ram_we_o   (ram_we_o),
    .ram_addr_o (ram_addr_o),
    .ram_data_o (ram_data_o),
    .ram_data_i (ram_data_i),
    .state_o    (state_o)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- RAM model (registered read) ----------------
  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    mem[8'h04] = 32'h0000_0013;      // word at byte address 0x10
    ref_mem[8'h04] = 32'h0000_0013;
  end

  always @(posedge clk) begin
    if (ram_we_o) mem[ram_addr_o[9:2]] <= ram_data_o;
    ram_data_i <= mem[ram_addr_o[9:2]];
  end

  // ---------------- reference model (transaction timeline) ----------------
  // m_age = cycles since the grant (0 = no transaction in flight).
  // Owner encoding in the model: 0 = fetch, 1 = data.
  bit          model_on = 1'b0;
  int          m_age = 0;
  int          m_last = 1;
  int          t_own = 0;
  int          w;
  logic        t_we = 1'b0;
  logic [31:0] t_addr = '0;
  logic [31:0] t_wdata = '0;
  logic [31:0] e_addr = '0;
  logic [31:0] e_data = '0;

  always @(posedge clk) begin
    // A store drives the RAM for the whole ACCESS cycle, so it lands even if
    // reset is sampled at the end of that cycle.
    if (m_age == 1 && t_we) ref_mem[t_addr[9:2]] = t_wdata;
    if (reset) begin
      model_on = 1'b1;
      m_age = 0;
      m_last = 1;
      e_addr = '0;
      e_data = '0;
    end else if (model_on) begin
      if (m_age == 0) begin
        if (if_req_i || d_req_i) begin
          if (if_req_i && d_req_i) w = RR ? ((m_last == 1) ? 0 : 1) : 1;
          else w = d_req_i ? 1 : 0;
          t_own = w;
          m_last = w;
          if (w == 1) begin
            t_we = d_we_i;
            t_addr = d_addr_i;
            t_wdata = d_wdata_i;
            e_data = d_wdata_i;
          end else begin
            t_we = 1'b0;
            t_addr = if_addr_i;
          end
          e_addr = t_addr;
          m_age = 1;
        end
      end else if (m_age == 1) begin
        m_age = 2;
      end else begin
        m_age = 0;
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  int we_cnt = 0;
  always @(negedge clk) begin
    if (model_on) begin
      if (ram_we_o) we_cnt++;
      chk("ram_we",   {31'd0, ram_we_o}, {31'd0, (m_age == 1) && t_we});
      chk("ram_addr", ram_addr_o, e_addr);
      chk("ram_data", ram_data_o, e_data);
      chk("if_ack",   {31'd0, if_ack_o}, {31'd0, (m_age == 2) && (t_own == 0)});
      chk("d_ack",    {31'd0, d_ack_o},  {31'd0, (m_age == 2) && (t_own == 1)});
      chk("ack_excl", {31'd0, if_ack_o & d_ack_o}, 32'd0);
      if (m_age == 2 && !t_we) begin
        if (t_own == 0) chk("if_rdata", if_rdata_o, ref_mem[t_addr[9:2]]);
        else            chk("d_rdata",  d_rdata_o,  ref_mem[t_addr[9:2]]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic do_if(input logic [31:0] addr, output logic [31:0] rdata,
                       output int lat, output int acyc);
    @(posedge clk); #1;
    if_req_i = 1'b1;
    if_addr_i = addr;
    lat = -1; rdata = '0; acyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if_ack_o) begin lat = i; rdata = if_rdata_o; acyc = cyc; break; end
    end
    @(posedge clk); #1;
    if_req_i = 1'b0;
    if (lat < 0) begin
      checks++; fails++;
      $display("FAIL if_timeout actual=no_ack expected=ack");
    end
  endtask

  task automatic do_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output int lat, output int acyc);
    @(posedge clk); #1;
    d_req_i = 1'b1;
    d_we_i = we;
    d_addr_i = addr;
    d_wdata_i = wdata;
    lat = -1; rdata = '0; acyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (d_ack_o) begin lat = i; rdata = d_rdata_o; acyc = cyc; break; end
    end
    @(posedge clk); #1;
    d_req_i = 1'b0;
    d_we_i = 1'b0;
    if (lat < 0) begin
      checks++; fails++;
      $display("FAIL d_timeout actual=no_ack expected=ack");
    end
  endtask

  // ---------------- directed stimulus ----------------
  logic [31:0] rd_if, rd_d;
  int lat_if, lat_d, cyc_if, cyc_d;
  int ack_q[$];
  int exp4[4];
  bit got;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_if_rdata", if_rdata_o, 32'd0);
    chk("rst_d_rdata",  d_rdata_o,  32'd0);
    chk("rst_ram_addr", ram_addr_o, 32'd0);
    #1 reset = 1'b0;

    // Fetch-only read of 0x10.
    we_cnt = 0;
    do_if(32'h0000_0010, rd_if, lat_if, cyc_if);
    chk("t1_if_lat",   lat_if, 32'd2);
    chk("t1_if_rdata", rd_if, 32'h0000_0013);
    chk("t1_no_write", we_cnt, 32'd0);

    // Store then load at 0x40.
    we_cnt = 0;
    do_d(1'b1, 32'h40, 32'hDEAD_BEEF, rd_d, lat_d, cyc_d);
    chk("t2_st_lat",  lat_d, 32'd2);
    chk("t2_we_once", we_cnt, 32'd1);
    do_d(1'b0, 32'h40, 32'h0, rd_d, lat_d, cyc_d);
    chk("t2_ld_rdata", rd_d, 32'hDEAD_BEEF);

    // Simultaneous requests from reset.
    do_reset();
    fork
      do_if(32'h10, rd_if, lat_if, cyc_if);
      do_d(1'b0, 32'h40, 32'h0, rd_d, lat_d, cyc_d);
    join
    if (RR) begin
      chk("t3_if_first_lat", lat_if, 32'd2);
      chk("t3_d_after_if",   cyc_d - cyc_if, 32'd3);
    end else begin
      chk("t3_d_first_lat",  lat_d, 32'd2);
      chk("t3_if_after_d",   cyc_if - cyc_d, 32'd3);
    end
    chk("t3_if_rdata", rd_if, 32'h0000_0013);
    chk("t3_d_rdata",  rd_d,  32'hDEAD_BEEF);

    // Both ports requesting continuously for 12 cycles.
    do_reset();
    if (RR) exp4 = '{0, 1, 0, 1};
    else    exp4 = '{1, 1, 1, 1};
    @(posedge clk); #1;
    if_req_i = 1'b1; if_addr_i = 32'h10;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h40;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (if_ack_o) ack_q.push_back(0);
      if (d_ack_o)  ack_q.push_back(1);
    end
    @(posedge clk); #1;
    if_req_i = 1'b0; d_req_i = 1'b0;
    chk("t4_ack_count", ack_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t4_ack_order", (i < ack_q.size()) ? ack_q[i] : -1, exp4[i]);
    end
    repeat (3) @(posedge clk);

    // Reset during ACCESS of a store; the store is reissued afterwards.
    @(posedge clk); #1;
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h80; d_wdata_i = 32'h1234_5678;
    @(posedge clk); #1;             // granted: now in ACCESS
    reset = 1'b1;
    @(negedge clk);
    chk("t5_we_in_access", {31'd0, ram_we_o}, 32'd1);
    @(posedge clk); #1;             // reset sampled
    reset = 1'b0;
    @(negedge clk);
    chk("t5_we_after_rst",   {31'd0, ram_we_o}, 32'd0);
    chk("t5_d_ack_after",    {31'd0, d_ack_o},  32'd0);
    chk("t5_addr_after_rst", ram_addr_o, 32'd0);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (d_ack_o) begin got = 1'b1; break; end
    end
    chk("t5_reissue_ack", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    d_req_i = 1'b0; d_we_i = 1'b0;
    do_d(1'b0, 32'h80, 32'h0, rd_d, lat_d, cyc_d);
    chk("t5_ld_rdata", rd_d, 32'h1234_5678);

    // Address change during ACCESS is ignored.
    @(posedge clk); #1;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h40;
    @(posedge clk); #1;             // ACCESS
    d_addr_i = 32'h10;
    @(negedge clk);
    chk("t6_ram_addr", ram_addr_o, 32'h40);
    got = 1'b0; rd_d = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (d_ack_o) begin got = 1'b1; rd_d = d_rdata_o; break; end
    end
    chk("t6_ack",   {31'd0, got}, 32'd1);
    chk("t6_rdata", rd_d, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    d_req_i = 1'b0;
    repeat (4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  // Global watchdog so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
